// File: rtl/gf_poly_reducer.sv
// gf_poly_reducer: bit-serial reduction of a 2N-bit carry-less product
// modulo (x^N + poly). One quotient bit is retired per clock, from the top bit down.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a product/poly pair; in_ready is high
//   REDUCE | clearing rem[N+k] for k = N-1 down to 0, one bit per clock
//   DONE   | result presented with out_valid until the consumer takes it
module gf_poly_reducer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] product,
  input  logic [DATA_WIDTH-1:0]   poly,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result
);

  localparam int N  = DATA_WIDTH;
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*N-1:0]  rem_q, rem_d;
  logic [N-1:0]    poly_q, poly_d;
  logic [KW-1:0]   k_q, k_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    result_q, result_d;

  logic [N-1:0]    rem_hi;
  logic [2*N-1:0]  modulus;
  logic [2*N-1:0]  step_rem;

  assign rem_hi  = rem_q[2*N-1:N];
  assign modulus = {{(N-1){1'b0}}, 1'b1, poly_q};

  // One division step: cancel coefficient x^(N+k) by xoring in the modulus shifted by k.
  always_comb begin
    step_rem = rem_q;
    if (rem_hi[k_q]) begin
      step_rem = rem_q ^ (modulus << k_q);
    end
  end

  // Next-state and datapath update for the IDLE -> REDUCE -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    poly_d      = poly_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = product;
          poly_d  = poly;
          k_d     = KW'(N - 1);
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        rem_d = step_rem;
        if (k_q == '0) begin
          // Upper half is now zero; the low half is the residue.
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = step_rem[N-1:0];
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        // No same-edge hand-off to a new accept: IDLE is always visited.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      poly_q      <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      poly_q      <= poly_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_gf_poly_reducer.sv
// Bench for gf_poly_reducer: directed N=8 cases plus a random N=32 sweep,
// checked against a residue model built from x^i mod m tables.
module tb_gf_poly_reducer;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [15:0] product8;
  logic [7:0]  poly8, result8;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [63:0] product32;
  logic [31:0] poly32, result32;

  int n_chk  = 0;
  int n_fail = 0;

  gf_poly_reducer #(.DATA_WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .product   (product8),
    .poly      (poly8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .result    (result8)
  );

  gf_poly_reducer #(.DATA_WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .product   (product32),
    .poly      (poly32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .result    (result32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // product mod (x^n + poly): xor together x^i mod m for every set bit i.
  // x^i mod m is stepped by multiply-by-x with a fold of the x^n term.
  function automatic logic [31:0] ref_mod(input logic [63:0] p, input logic [31:0] pl, input int n);
    logic [31:0] mask, xp, acc;
    logic        carry;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    xp   = 32'h1;
    acc  = 32'h0;
    for (int i = 0; i < 2 * n; i++) begin
      if (p[i]) acc ^= xp;
      carry = xp[n-1];
      xp    = (xp << 1) & mask;
      if (carry) xp ^= (pl & mask);
    end
    return acc;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One N=8 operation: latency, result, optional back-pressure and busy in_valid noise.
  task automatic run_op8(input logic [15:0] p, input logic [7:0] pl, input logic [7:0] exp,
                         input int hold, input bit noise);
    int cyc;
    product8  = p;
    poly8     = pl;
    in_valid8 = 1'b1;
    chk("rdy_before_accept", 64'(in_ready8), 64'd1);
    tick();
    in_valid8 = 1'b0;
    product8  = 16'($urandom);
    poly8     = 8'($urandom);
    cyc = 0;
    while (!out_valid8 && cyc < 40) begin
      if (noise) in_valid8 = 1'($urandom_range(0, 1));
      if (cyc == 2) chk("rdy_in_reduce", 64'(in_ready8), 64'd0);
      tick();
      cyc++;
    end
    chk("latency8", 64'(cyc), 64'd8);
    chk("result8", 64'(result8), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      if (noise) in_valid8 = 1'($urandom_range(0, 1));
      tick();
      chk("hold_valid", 64'(out_valid8), 64'd1);
      chk("hold_result", 64'(result8), 64'(exp));
      chk("hold_ready", 64'(in_ready8), 64'd0);
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    chk("drain_valid", 64'(out_valid8), 64'd0);
    chk("drain_ready", 64'(in_ready8), 64'd1);
    chk("result_kept", 64'(result8), 64'(exp));
  endtask

  task automatic run_op32(input logic [63:0] p, input logic [31:0] pl);
    int          cyc;
    logic [31:0] exp;
    exp        = ref_mod(p, pl, 32);
    product32  = p;
    poly32     = pl;
    in_valid32 = 1'b1;
    tick();
    in_valid32 = 1'b0;
    product32  = {$urandom, $urandom};
    cyc = 0;
    while (!out_valid32 && cyc < 80) begin
      tick();
      cyc++;
    end
    chk("latency32", 64'(cyc), 64'd32);
    chk("result32", 64'(result32), 64'(exp));
    out_ready32 = 1'b1;
    tick();
    out_ready32 = 1'b0;
    chk("drain32", 64'(out_valid32), 64'd0);
  endtask

  initial begin
    logic [15:0] vec [4];
    logic [7:0]  vexp [4];
    logic [15:0] rp;
    logic [7:0]  rpl;
    int          idx, got, last;
    logic        rdy_prev;
    bit          early;

    rst_n       = 1'b0;
    in_valid8   = 1'b0; out_ready8  = 1'b0; product8  = '0; poly8  = '0;
    in_valid32  = 1'b0; out_ready32 = 1'b0; product32 = '0; poly32 = '0;
    #12;
    chk("rst_valid", 64'(out_valid8), 64'd0);
    chk("rst_result", 64'(result8), 64'd0);
    chk("rst_ready", 64'(in_ready8), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Known AES-field residues.
    run_op8(16'h2B79, 8'h1B, 8'hC1, 0, 1'b0);
    run_op8(16'h3F7E, 8'h1B, 8'h01, 0, 1'b0);
    run_op8(16'h0100, 8'h1B, 8'h1B, 0, 1'b0);
    run_op8(16'h0000, 8'h1B, 8'h00, 0, 1'b0);
    run_op8(16'hFFFF, 8'h00, 8'hFF, 0, 1'b0);
    // x^15 mod x^8+x^4+x^3+x+1 = 0x2F (x^11 would be 0xD8)
    run_op8(16'h8000, 8'h1B, 8'h2F, 0, 1'b0);
    run_op8(16'h00A5, 8'h1B, 8'hA5, 0, 1'b0);

    // Back-pressure with in_valid noise while busy.
    run_op8(16'h2B79, 8'h1B, 8'hC1, 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_phantom_op", 64'(out_valid8), 64'd0);
    end

    // Random N=8 against the model.
    for (int i = 0; i < 6; i++) begin
      rp  = 16'($urandom);
      rpl = 8'($urandom);
      run_op8(rp, rpl, 8'(ref_mod(64'(rp), 32'(rpl), 8)), i % 2, 1'(i % 2));
    end

    // Streaming with in_valid and out_ready tied high.
    for (int i = 0; i < 4; i++) begin
      vec[i]  = 16'($urandom);
      vexp[i] = 8'(ref_mod(64'(vec[i]), 32'h1B, 8));
    end
    idx = 0; got = 0; last = -1;
    poly8 = 8'h1B; product8 = vec[0];
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    rdy_prev = in_ready8;
    for (int c = 0; c < 80 && got < 4; c++) begin
      tick();
      if (rdy_prev && in_valid8) begin
        idx++;
        if (idx < 4) product8 = vec[idx];
        else in_valid8 = 1'b0;
      end
      if (out_valid8) begin
        chk("stream_result", 64'(result8), 64'(vexp[got]));
        if (got > 0) chk("stream_interval", 64'(c - last), 64'd10);
        last = c;
        got++;
      end
      rdy_prev = in_ready8;
    end
    chk("stream_count", 64'(got), 64'd4);
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    tick();

    // Reset in the middle of REDUCE aborts the operation.
    product8 = 16'h2B79; poly8 = 8'h1B; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid8), 64'd0);
    chk("abort_result", 64'(result8), 64'd0);
    chk("abort_ready", 64'(in_ready8), 64'd1);
    tick();
    rst_n = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid8) early = 1'b1;
    end
    chk("abort_no_result", 64'(early), 64'd0);
    run_op8(16'h3F7E, 8'h1B, 8'h01, 0, 1'b0);

    // N=32: boundaries then a random sweep.
    run_op32(64'hFFFF_FFFF_FFFF_FFFF, 32'h0);
    run_op32({32'h0, $urandom}, 32'h0000_008D);
    run_op32(64'h8000_0000_0000_0000, 32'h0000_008D);
    for (int i = 0; i < 25; i++) begin
      run_op32({$urandom, $urandom}, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
